// File: rtl/cache_pkg.sv
// Shared widths, address field positions, controller states and transfer timing
// for the direct-mapped write-back cache.
package cache_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int DATA_WIDTH      = 8;
    localparam int ADDR_WIDTH_SRAM = 8;
    localparam int TAG_SIZE        = 8;
    localparam int DEPTH           = 8;

    localparam int OFFSET_BITS = 5;
    localparam int INDEX_BITS  = 3;
    localparam int INDEX_LSB   = OFFSET_BITS;
    localparam int TAG_LSB     = OFFSET_BITS + INDEX_BITS;
    localparam int BLOCK_SIZE  = 32;
    localparam int SRAM_DEPTH  = 1 << ADDR_WIDTH_SRAM;
    localparam int SDRAM_DEPTH = 1 << ADDR_WIDTH;

    // Each block transfer takes two cycles per byte.
    localparam int XFER_CYCLES       = 2 * BLOCK_SIZE;
    localparam int CLEAN_MISS_CYCLES = XFER_CYCLES + 3;
    localparam int DIRTY_MISS_CYCLES = 2 * XFER_CYCLES + 3;

    typedef logic [TAG_SIZE-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [5:0]             xfer_cnt_t;

    localparam xfer_cnt_t XFER_LOAD = xfer_cnt_t'(XFER_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        DONE
    } state_t;

    // The transfer counter runs down from XFER_LOAD; each byte spends an odd
    // count (first cycle) then an even count (second cycle).
    function automatic offset_t xfer_beat(input xfer_cnt_t cnt);
        return ~cnt[5:1];
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Cache controller: request FSM, block transfer sequencing and the tag/valid/dirty store.
// state     | meaning
// IDLE      | ready, waiting for cs_cpu
// LOOKUP    | compare latched tag against the store
// WRITEBACK | copy dirty block SRAM -> SDRAM, two cycles per byte
// FILL      | copy block SDRAM -> SRAM, two cycles per byte
// DONE      | hit access performed, return to IDLE
module cache_controller
    import cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      address_cpu,
    input  logic [DATA_WIDTH-1:0]      dout_cpu,
    input  logic                       wr_rd_cpu,
    input  logic                       cs_cpu,
    output logic                       rdy_cpu,
    output logic [ADDR_WIDTH-1:0]      address_sdram,
    output logic                       wr_rd_sdram,
    output logic                       mstrb_sdram,
    output logic                       mux_sel,
    output logic                       demux_sel,
    output logic                       wen_sram,
    output logic [ADDR_WIDTH_SRAM-1:0] address_sram,
    output logic [DATA_WIDTH-1:0]      data_cpu,
    output logic                       load_din
);

    state_t    state, state_nxt;
    xfer_cnt_t cnt, cnt_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_rd_q;
    tag_t                  tag_mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      dirty;

    tag_t    tag;
    index_t  index;
    offset_t offset;
    offset_t beat;
    logic    phase_a;
    logic    hit;

    logic                       rdy_nxt;
    logic [ADDR_WIDTH-1:0]      address_sdram_nxt;
    logic                       wr_rd_sdram_nxt;
    logic                       mstrb_sdram_nxt;
    logic                       mux_sel_nxt;
    logic                       demux_sel_nxt;
    logic                       wen_sram_nxt;
    logic [ADDR_WIDTH_SRAM-1:0] address_sram_nxt;

    assign tag    = addr_q[TAG_LSB +: TAG_SIZE];
    assign index  = addr_q[INDEX_LSB +: INDEX_BITS];
    assign offset = addr_q[OFFSET_BITS-1:0];
    assign hit    = valid[index] && (tag_mem[index] == tag);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cs_cpu) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = DONE;
                end else if (valid[index] && dirty[index]) begin
                    state_nxt = WRITEBACK;
                    cnt_nxt   = XFER_LOAD;
                end else begin
                    state_nxt = FILL;
                    cnt_nxt   = XFER_LOAD;
                end
            end
            WRITEBACK: begin
                if (cnt == '0) begin
                    state_nxt = FILL;
                    cnt_nxt   = XFER_LOAD;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            FILL: begin
                if (cnt == '0) state_nxt = LOOKUP;
                else           cnt_nxt   = cnt - 6'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state/count and then registered,
    // so each cycle's outputs match the state occupying that cycle.
    assign beat    = xfer_beat(cnt_nxt);
    assign phase_a = cnt_nxt[0];

    always_comb begin
        rdy_nxt           = (state_nxt == IDLE);
        address_sdram_nxt = '0;
        wr_rd_sdram_nxt   = 1'b0;
        mstrb_sdram_nxt   = 1'b0;
        mux_sel_nxt       = 1'b0;
        demux_sel_nxt     = 1'b0;
        wen_sram_nxt      = 1'b0;
        address_sram_nxt  = '0;
        case (state_nxt)
            WRITEBACK: begin
                if (phase_a) begin
                    address_sram_nxt = {index, beat};
                    demux_sel_nxt    = 1'b1;
                end else begin
                    mstrb_sdram_nxt   = 1'b1;
                    wr_rd_sdram_nxt   = 1'b1;
                    address_sdram_nxt = {tag_mem[index], index, beat};
                end
            end
            FILL: begin
                if (phase_a) begin
                    mstrb_sdram_nxt   = 1'b1;
                    address_sdram_nxt = {tag, index, beat};
                end else begin
                    wen_sram_nxt     = 1'b1;
                    mux_sel_nxt      = 1'b1;
                    address_sram_nxt = {index, beat};
                end
            end
            DONE: begin
                address_sram_nxt = {index, offset};
                wen_sram_nxt     = wr_rd_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            valid         <= '0;
            dirty         <= '0;
            addr_q        <= '0;
            data_cpu      <= '0;
            wr_rd_q       <= 1'b0;
            rdy_cpu       <= 1'b1;
            address_sdram <= '0;
            wr_rd_sdram   <= 1'b0;
            mstrb_sdram   <= 1'b0;
            mux_sel       <= 1'b0;
            demux_sel     <= 1'b0;
            wen_sram      <= 1'b0;
            address_sram  <= '0;
            load_din      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rdy_cpu       <= rdy_nxt;
            address_sdram <= address_sdram_nxt;
            wr_rd_sdram   <= wr_rd_sdram_nxt;
            mstrb_sdram   <= mstrb_sdram_nxt;
            mux_sel       <= mux_sel_nxt;
            demux_sel     <= demux_sel_nxt;
            wen_sram      <= wen_sram_nxt;
            address_sram  <= address_sram_nxt;
            // SRAM read data appears the cycle after DONE presents the address.
            load_din      <= (state == DONE) && !wr_rd_q;
            if (state == IDLE && cs_cpu) begin
                addr_q   <= address_cpu;
                data_cpu <= dout_cpu;
                wr_rd_q  <= wr_rd_cpu;
            end
            if (state == LOOKUP && hit && wr_rd_q) dirty[index] <= 1'b1;
            if (state == WRITEBACK && cnt == '0)   dirty[index] <= 1'b0;
            if (state == FILL && cnt == '0)        valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == FILL && cnt == '0) tag_mem[index] <= tag;
    end

endmodule

// File: rtl/cache_top_core.sv
// Cache subsystem top: controller, 256-byte SRAM data array, 64 KB SDRAM model
// and the SRAM data-in mux / data-out demux.
module cache_top_core
    import cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      Address_cpu,
    input  logic [DATA_WIDTH-1:0]      DOut_cpu,
    input  logic                       wr_rd_cpu,
    input  logic                       cs_cpu,
    output logic                       rdy_cpu,
    output logic [DATA_WIDTH-1:0]      DIn_cpu,
    output logic [ADDR_WIDTH-1:0]      Address_sdram,
    output logic                       wr_rd_sdram,
    output logic                       mstrb_sdram,
    output logic                       mux_sel,
    output logic                       demux_sel,
    output logic                       wen_sram,
    output logic [ADDR_WIDTH_SRAM-1:0] address_cache_ctrl_sram
);

    logic [DATA_WIDTH-1:0] sram_mem  [SRAM_DEPTH];
    logic [DATA_WIDTH-1:0] sdram_mem [SDRAM_DEPTH];
    logic [DATA_WIDTH-1:0] sram_q;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sdram_q;
    logic [DATA_WIDTH-1:0] sdram_din;
    logic [DATA_WIDTH-1:0] data_cpu;
    logic                  load_din;
    logic                  demux_q;

    cache_controller u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .address_cpu   (Address_cpu),
        .dout_cpu      (DOut_cpu),
        .wr_rd_cpu     (wr_rd_cpu),
        .cs_cpu        (cs_cpu),
        .rdy_cpu       (rdy_cpu),
        .address_sdram (Address_sdram),
        .wr_rd_sdram   (wr_rd_sdram),
        .mstrb_sdram   (mstrb_sdram),
        .mux_sel       (mux_sel),
        .demux_sel     (demux_sel),
        .wen_sram      (wen_sram),
        .address_sram  (address_cache_ctrl_sram),
        .data_cpu      (data_cpu),
        .load_din      (load_din)
    );

    assign sram_din  = mux_sel ? sdram_q : data_cpu;
    assign sdram_din = demux_q ? sram_q : '0;

    always_ff @(posedge clk) begin
        if (wen_sram) sram_mem[address_cache_ctrl_sram] <= sram_din;
        sram_q <= sram_mem[address_cache_ctrl_sram];
    end

    // Storage holds data XOR the low address byte, so zero-initialised
    // storage reads back as the preload pattern mem[a] = a[7:0].
    always_ff @(posedge clk) begin
        if (mstrb_sdram && wr_rd_sdram)
            sdram_mem[Address_sdram] <= sdram_din ^ Address_sdram[DATA_WIDTH-1:0];
        if (mstrb_sdram && !wr_rd_sdram)
            sdram_q <= sdram_mem[Address_sdram] ^ Address_sdram[DATA_WIDTH-1:0];
    end

    // demux_sel is tagged on the address cycle; the SRAM data follows a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            demux_q <= 1'b0;
            DIn_cpu <= '0;
        end else begin
            demux_q <= demux_sel;
            if (load_din) DIn_cpu <= sram_q;
        end
    end

endmodule

// File: tb/tb_cache_top_core.sv
// Directed bench for cache_top_core: hit, clean miss, dirty miss and mid-fill reset.
module tb_cache_top_core;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Address_cpu;
    logic [7:0]  DOut_cpu;
    logic        wr_rd_cpu;
    logic        cs_cpu;
    logic        rdy_cpu;
    logic [7:0]  DIn_cpu;
    logic [15:0] Address_sdram;
    logic        wr_rd_sdram;
    logic        mstrb_sdram;
    logic        mux_sel;
    logic        demux_sel;
    logic        wen_sram;
    logic [7:0]  address_cache_ctrl_sram;

    cache_top_core dut (
        .clk                     (clk),
        .rst                     (rst),
        .Address_cpu             (Address_cpu),
        .DOut_cpu                (DOut_cpu),
        .wr_rd_cpu               (wr_rd_cpu),
        .cs_cpu                  (cs_cpu),
        .rdy_cpu                 (rdy_cpu),
        .DIn_cpu                 (DIn_cpu),
        .Address_sdram           (Address_sdram),
        .wr_rd_sdram             (wr_rd_sdram),
        .mstrb_sdram             (mstrb_sdram),
        .mux_sel                 (mux_sel),
        .demux_sel               (demux_sel),
        .wen_sram                (wen_sram),
        .address_cache_ctrl_sram (address_cache_ctrl_sram)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [16:0] strb_log [$];
    logic [8:0]  wen_log  [$];

    always @(negedge clk) begin
        if (mstrb_sdram) strb_log.push_back({wr_rd_sdram, Address_sdram});
        if (wen_sram)    wen_log.push_back({mux_sel, address_cache_ctrl_sram});
    end

    int         r_low, r_nrd, r_nwr, r_rderr, r_wrerr, r_nwen;
    logic [8:0] r_wen_first, r_wen_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after DIn_cpu has been updated.
    task automatic req(input logic [15:0] a, input logic [7:0] d, input logic wr,
                       input logic [15:0] rd_base, input logic [15:0] wr_base);
        int s0, w0;
        logic [16:0] e;
        s0 = strb_log.size();
        w0 = wen_log.size();
        Address_cpu = a;
        DOut_cpu    = d;
        wr_rd_cpu   = wr;
        cs_cpu      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs_cpu = 1'b0;
        r_low  = 0;
        while (rdy_cpu !== 1'b1 && r_low < DIRTY_MISS_CYCLES + 40) begin
            r_low++;
            @(negedge clk);
        end
        @(negedge clk);
        r_nrd = 0; r_nwr = 0; r_rderr = 0; r_wrerr = 0;
        for (int i = s0; i < strb_log.size(); i++) begin
            e = strb_log[i];
            if (e[16]) begin
                if (e[15:0] !== 16'(wr_base + r_nwr)) r_wrerr++;
                r_nwr++;
            end else begin
                if (e[15:0] !== 16'(rd_base + r_nrd)) r_rderr++;
                r_nrd++;
            end
        end
        r_nwen      = wen_log.size() - w0;
        r_wen_first = (r_nwen > 0) ? wen_log[w0] : 9'h1FF;
        r_wen_last  = (r_nwen > 0) ? wen_log[wen_log.size() - 1] : 9'h1FF;
    endtask

    initial begin
        rst = 1'b1; cs_cpu = 1'b0; wr_rd_cpu = 1'b0;
        Address_cpu = 16'h0; DOut_cpu = 8'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(rdy_cpu), 1);
        chk("rst_addrs", 32'({Address_sdram, address_cache_ctrl_sram}), 0);
        chk("rst_ctl", 32'({DIn_cpu, wr_rd_sdram, mstrb_sdram, mux_sel, demux_sel, wen_sram}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Cold read: clean miss filling 0x1220..0x123F.
        req(16'h1234, 8'h00, 1'b0, 16'h1220, 16'h0000);
        chk("cold_low", 32'(r_low), 67);
        chk("cold_nrd", 32'(r_nrd), 32);
        chk("cold_rderr", 32'(r_rderr), 0);
        chk("cold_nwr", 32'(r_nwr), 0);
        chk("cold_nwen", 32'(r_nwen), 32);
        chk("cold_wen_first", 32'(r_wen_first), 32'h120);
        chk("cold_wen_last", 32'(r_wen_last), 32'h13F);
        chk("cold_din", 32'(DIn_cpu), 32'h34);

        // Write hit then read hit.
        req(16'h1235, 8'hAB, 1'b1, 16'h0000, 16'h0000);
        chk("wr_hit_low", 32'(r_low), 2);
        chk("wr_hit_strb", 32'(r_nrd + r_nwr), 0);
        chk("wr_hit_nwen", 32'(r_nwen), 1);
        chk("wr_hit_wen", 32'(r_wen_first), 32'h035);
        req(16'h1235, 8'h00, 1'b0, 16'h0000, 16'h0000);
        chk("rd_hit_low", 32'(r_low), 2);
        chk("rd_hit_strb", 32'(r_nrd + r_nwr), 0);
        chk("rd_hit_din", 32'(DIn_cpu), 32'hAB);
        req(16'h1236, 8'h00, 1'b0, 16'h0000, 16'h0000);
        chk("rd_hit2_low", 32'(r_low), 2);
        chk("rd_hit2_din", 32'(DIn_cpu), 32'h36);

        // Same index, different tag: dirty line written back, then refilled.
        req(16'h5635, 8'h00, 1'b0, 16'h5620, 16'h1220);
        chk("dirty_low", 32'(r_low), 131);
        chk("dirty_nwr", 32'(r_nwr), 32);
        chk("dirty_wrerr", 32'(r_wrerr), 0);
        chk("dirty_nrd", 32'(r_nrd), 32);
        chk("dirty_rderr", 32'(r_rderr), 0);
        chk("dirty_din", 32'(DIn_cpu), 32'h35);

        // Clean victim: no write-back, written-back byte fetched from SDRAM.
        req(16'h1235, 8'h00, 1'b0, 16'h1220, 16'h0000);
        chk("clean_low", 32'(r_low), 67);
        chk("clean_nwr", 32'(r_nwr), 0);
        chk("clean_nrd", 32'(r_nrd), 32);
        chk("clean_din", 32'(DIn_cpu), 32'hAB);

        // Reset in the middle of a fill.
        Address_cpu = 16'h1240; wr_rd_cpu = 1'b0; cs_cpu = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs_cpu = 1'b0;
        repeat (CLEAN_MISS_CYCLES / 3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rdy", 32'(rdy_cpu), 1);
        chk("midrst_mstrb", 32'(mstrb_sdram), 0);
        chk("midrst_ctl", 32'({wr_rd_sdram, mux_sel, demux_sel, wen_sram, address_cache_ctrl_sram}), 0);
        rst = 1'b0;
        @(negedge clk);
        req(16'h1240, 8'h00, 1'b0, 16'h1240, 16'h0000);
        chk("after_rst_low", 32'(r_low), 67);
        chk("after_rst_nrd", 32'(r_nrd), 32);
        chk("after_rst_din", 32'(DIn_cpu), 32'h40);
        req(16'h1235, 8'h00, 1'b0, 16'h1220, 16'h0000);
        chk("after_rst_miss_low", 32'(r_low), 67);
        chk("after_rst_keep_din", 32'(DIn_cpu), 32'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
